// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, boot image and state type for imem_sync
package imem_pkg;

    localparam logic [31:0] NOP = 32'h00000000;
    localparam int BOOT_LEN = 4;

    // addi x1,xzr,#15 ; nop ; nop ; stur x1,[x0,#0]
    localparam logic [31:0] BOOT_IMAGE [BOOT_LEN] = '{
        32'h91003fe1,
        NOP,
        NOP,
        32'hf8000001
    };

    typedef enum logic {
        INIT,
        RUN
    } imem_state_t;

    function automatic logic [31:0] boot_word(input int idx);
        if (idx < BOOT_LEN) begin
            return BOOT_IMAGE[idx];
        end
        return NOP;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - simple dual-port RAM, one write port, one read-first synchronous read port
module imem_ram #(
    parameter int N      = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [N-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [N-1:0]      rdata
);

    logic [N-1:0] mem [DEPTH];

    // Non-blocking read of the same array gives old data on a same-word write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_sync.sv
// rtl/imem_sync.sv - registered instruction memory with boot copy, stall, flush and reload port
module imem_sync
    import imem_pkg::*;
#(
    parameter int N      = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int PC_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   pc,
    input  logic              en,
    input  logic              flush,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [N-1:0]      prog_data,
    output logic [N-1:0]      q,
    output logic              valid,
    output logic              ready,
    output logic              misalign,
    output logic              oob
);

    imem_state_t       state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              ready_n, valid_n, misalign_n, oob_n;
    logic              q_nop, q_nop_n;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [N-1:0]      ram_wdata;
    logic [N-1:0]      ram_rdata;

    logic              pc_mis, pc_oob;

    assign pc_mis = (pc[1:0] != 2'b00);
    assign pc_oob = (pc[PC_W-1:ADDR_W+2] != '0);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        ready_n    = ready;
        valid_n    = valid;
        misalign_n = misalign;
        oob_n      = oob;
        q_nop_n    = q_nop;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_waddr  = prog_addr;
        ram_wdata  = prog_data;

        unique case (state)
            INIT: begin
                ram_we    = ~reset;
                ram_waddr = cnt;
                ram_wdata = N'(boot_word(int'(cnt)));
                cnt_n     = cnt + 1'b1;
                q_nop_n   = 1'b1;
                valid_n   = 1'b0;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_n = RUN;
                    ready_n = 1'b1;
                end
            end
            RUN: begin
                ram_we = prog_we & ~reset;
                if (flush) begin
                    q_nop_n    = 1'b1;
                    valid_n    = 1'b0;
                    misalign_n = 1'b0;
                    oob_n      = 1'b0;
                end else if (en) begin
                    ram_re     = 1'b1;
                    q_nop_n    = pc_mis | pc_oob;
                    valid_n    = 1'b1;
                    misalign_n = pc_mis;
                    oob_n      = pc_oob;
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            cnt      <= '0;
            ready    <= 1'b0;
            valid    <= 1'b0;
            misalign <= 1'b0;
            oob      <= 1'b0;
            q_nop    <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ready    <= ready_n;
            valid    <= valid_n;
            misalign <= misalign_n;
            oob      <= oob_n;
            q_nop    <= q_nop_n;
        end
    end

    imem_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (ram_re),
        .raddr(pc[ADDR_W+1:2]),
        .rdata(ram_rdata)
    );

    // Read data is stale across flush/reset/bad fetch; q_nop masks it to NOP.
    assign q = q_nop ? N'(NOP) : ram_rdata;

endmodule

// File: tb/tb_imem_sync.sv
// tb/tb_imem_sync.sv - directed self-checking bench for imem_sync
module tb_imem_sync;

    localparam int N      = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int PC_W   = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [PC_W-1:0]   pc;
    logic              en;
    logic              flush;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [N-1:0]      prog_data;
    logic [N-1:0]      q;
    logic              valid;
    logic              ready;
    logic              misalign;
    logic              oob;

    int tests = 0;
    int fails = 0;

    imem_sync #(
        .N     (N),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .PC_W  (PC_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .en       (en),
        .flush    (flush),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .q        (q),
        .valid    (valid),
        .ready    (ready),
        .misalign (misalign),
        .oob      (oob)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts edges until ready rises while hammering en/prog_we, which INIT must ignore.
    task automatic wait_ready(output int n, output int noisy);
        n = 0;
        noisy = 0;
        en = 1'b1;
        pc = '0;
        prog_we = 1'b1;
        prog_addr = '0;
        prog_data = 32'hffffffff;
        while (n < 100) begin
            step();
            n++;
            if (ready) break;
            if (valid || q != 0) noisy++;
        end
        en = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [63:0] addr, input logic [31:0] exp_q,
                         input logic exp_v, input logic exp_m, input logic exp_o);
        pc = addr;
        en = 1'b1;
        step();
        check({tag, "_q"}, q, exp_q);
        check({tag, "_valid"}, valid, exp_v);
        check({tag, "_mis"}, misalign, exp_m);
        check({tag, "_oob"}, oob, exp_o);
        en = 1'b0;
    endtask

    task automatic write(input logic [5:0] a, input logic [31:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    initial begin
        int n;
        int noisy;
        reset = 1'b1;
        pc = '0;
        en = 1'b0;
        flush = 1'b0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        step();
        step();
        check("rst_q", q, 0);
        check("rst_valid", valid, 0);
        check("rst_ready", ready, 0);
        check("rst_mis", misalign, 0);
        check("rst_oob", oob, 0);

        reset = 1'b0;
        wait_ready(n, noisy);
        check("boot_len", n, 64);
        check("boot_quiet", noisy, 0);

        fetch("f0", 0, 32'h91003fe1, 1, 0, 0);
        fetch("f4", 4, 32'h00000000, 1, 0, 0);
        fetch("f8", 8, 32'h00000000, 1, 0, 0);
        fetch("f12", 12, 32'hf8000001, 1, 0, 0);

        fetch("stall_pre", 0, 32'h91003fe1, 1, 0, 0);
        pc = 12;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_q", q, 32'h91003fe1);
            check("stall_valid", valid, 1);
        end

        flush = 1'b1;
        fetch("flush", 12, 32'h0, 0, 0, 0);
        flush = 1'b0;

        prog_we = 1'b1;
        prog_addr = 5;
        prog_data = 32'h8b1f03e2;
        fetch("wr_old", 20, 32'h0, 1, 0, 0);
        prog_we = 1'b0;
        fetch("wr_new", 20, 32'h8b1f03e2, 1, 0, 0);

        fetch("mis", 2, 32'h0, 1, 1, 0);
        fetch("oob", 256, 32'h0, 1, 0, 1);

        write(63, 32'h12345678);
        fetch("last", 252, 32'h12345678, 1, 0, 0);

        flush = 1'b1;
        write(6, 32'hcafef00d);
        flush = 1'b0;
        check("flush_wr_valid", valid, 0);
        fetch("flush_wr", 24, 32'hcafef00d, 1, 0, 0);

        write(0, 32'hdeadbeef);
        fetch("prog0", 0, 32'hdeadbeef, 1, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rr_ready", ready, 0);
        check("rr_valid", valid, 0);
        check("rr_q", q, 0);
        wait_ready(n, noisy);
        check("rr_len", n, 64);
        check("rr_quiet", noisy, 0);
        fetch("rr_f0", 0, 32'h91003fe1, 1, 0, 0);
        fetch("rr_last", 252, 32'h0, 1, 0, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check("mid_ready", ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready(n, noisy);
        check("mid_len", n, 64);
        fetch("mid_f12", 12, 32'hf8000001, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
